// File: rtl/simple_controller.sv
// Two-cycle-per-instruction sequencer for a 4-register datapath: fetch latches INSTR, exec drives CW.
// Optional macro SINGLE_STEP_EN adds a WAIT state released by STEP after each executed instruction.
module simple_controller (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [11:0] INSTR,
  input  logic        Z,
  input  logic        N,
  input  logic        STEP,
  output logic [3:0]  PC,
  output logic [12:0] CW,
  output logic [3:0]  Constant,
  output logic        OUT_LD,
  output logic        HALTED
);

`ifdef SINGLE_STEP_EN
  typedef enum logic [2:0] {StIdle, StFetch, StExec, StHalt, StWait} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;
`endif

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpMov = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpOr  = 4'h5;
  localparam logic [3:0] OpXor = 4'h6;
  localparam logic [3:0] OpNot = 4'h7;
  localparam logic [3:0] OpLdi = 4'h8;
  localparam logic [3:0] OpAdi = 4'h9;
  localparam logic [3:0] OpIn  = 4'hA;
  localparam logic [3:0] OpOut = 4'hB;
  localparam logic [3:0] OpBrz = 4'hC;
  localparam logic [3:0] OpBrn = 4'hD;
  localparam logic [3:0] OpJmp = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_pc;
  logic [3:0]  w_pc_next;
  logic [11:0] r_ir;

  logic [3:0]  w_op;
  logic [1:0]  w_dr;
  logic [1:0]  w_sa;
  logic [1:0]  w_sb;
  logic [3:0]  w_imm;
  logic [3:0]  w_fs;
  logic        w_mb;
  logic        w_md;
  logic        w_rw;
  logic        w_out_op;
  logic [3:0]  w_pc_inc;

`ifndef SINGLE_STEP_EN
  // STEP is a dead input in the default build.
  logic w_unused_step;
  assign w_unused_step = STEP;
`endif

  assign w_op     = r_ir[11:8];
  assign w_dr     = r_ir[7:6];
  assign w_sa     = r_ir[5:4];
  assign w_sb     = r_ir[3:2];
  assign w_imm    = r_ir[3:0];
  assign w_pc_inc = r_pc + 4'd1;

  // Function-select decode of the latched instruction; only applied to CW in EXEC.
  always_comb begin
    w_fs     = 4'b0000;
    w_mb     = 1'b0;
    w_md     = 1'b0;
    w_rw     = 1'b0;
    w_out_op = 1'b0;
    unique case (w_op)
      OpNop: ;
      OpMov: w_rw = 1'b1;
      OpAdd: begin w_fs = 4'b0010; w_rw = 1'b1; end
      OpSub: begin w_fs = 4'b0101; w_rw = 1'b1; end
      OpAnd: begin w_fs = 4'b1000; w_rw = 1'b1; end
      OpOr:  begin w_fs = 4'b1001; w_rw = 1'b1; end
      OpXor: begin w_fs = 4'b1010; w_rw = 1'b1; end
      OpNot: begin w_fs = 4'b1011; w_rw = 1'b1; end
      OpLdi: begin w_fs = 4'b1100; w_mb = 1'b1; w_rw = 1'b1; end
      OpAdi: begin w_fs = 4'b0010; w_mb = 1'b1; w_rw = 1'b1; end
      OpIn:  begin w_md = 1'b1; w_rw = 1'b1; end
      OpOut: w_out_op = 1'b1;
      OpBrz, OpBrn, OpJmp, OpHlt: ;
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    CW           = 13'd0;
    Constant     = 4'd0;
    OUT_LD       = 1'b0;
    HALTED       = 1'b0;
    case (r_state)
      StIdle: begin
        if (START) w_state_next = StFetch;
      end
      StFetch: begin
        w_state_next = StExec;
      end
      StExec: begin
        CW       = {w_dr, w_sa, w_sb, w_mb, w_fs, w_md, w_rw};
        Constant = w_imm;
        OUT_LD   = w_out_op;
`ifdef SINGLE_STEP_EN
        w_state_next = StWait;
`else
        w_state_next = StFetch;
`endif
        case (w_op)
          OpBrz:   w_pc_next = Z ? w_imm : w_pc_inc;
          OpBrn:   w_pc_next = N ? w_imm : w_pc_inc;
          OpJmp:   w_pc_next = w_imm;
          OpHlt: begin
            w_pc_next    = r_pc;
            w_state_next = StHalt;
          end
          default: w_pc_next = w_pc_inc;
        endcase
      end
      StHalt: begin
        HALTED = 1'b1;
        if (START) begin
          w_pc_next    = 4'd0;
          w_state_next = StFetch;
        end
      end
`ifdef SINGLE_STEP_EN
      StWait: begin
        if (STEP) w_state_next = StFetch;
      end
`endif
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_pc    <= 4'd0;
      r_ir    <= 12'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (r_state == StFetch) r_ir <= INSTR;
    end
  end

  assign PC = r_pc;

endmodule
